// File: rtl/alu_seq.sv
// Handshaked, width-parametrised ALU. Logic, add/sub and 1-bit shift ops finish in one cycle.
// N-bit shifts and the unsigned multiply are iterative, doing one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_hi,
    output logic             cout,
    output logic             zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NOT  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SBC  = 4'h7;
    localparam logic [3:0] OP_SHL1 = 4'h8;
    localparam logic [3:0] OP_SHR1 = 4'h9;
    localparam logic [3:0] OP_ASR1 = 4'hA;
    localparam logic [3:0] OP_ROR1 = 4'hB;
    localparam logic [3:0] OP_SHLN = 4'hC;
    localparam logic [3:0] OP_SHRN = 4'hD;
    localparam logic [3:0] OP_ASRN = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_hi_r;
    logic               cout_r;
    logic [3:0]         op_r;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sc_q;
    logic               sc_c;
    logic [WIDTH-1:0]   step_q;
    logic               step_c;
    logic [WIDTH:0]     psum;

    assign shamt     = b[SHAMT_W-1:0];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign q         = q_r;
    assign q_hi      = q_hi_r;
    assign cout      = cout_r;
    assign zero      = (q_r == '0);

    always_comb begin
        sc_q = '0;
        sc_c = 1'b0;
        case (op)
            OP_AND:  sc_q = a & b;
            OP_OR:   sc_q = a | b;
            OP_XOR:  sc_q = a ^ b;
            OP_NOT:  sc_q = ~a;
            OP_ADD:  {sc_c, sc_q} = {1'b0, a} + {1'b0, b};
            OP_ADC:  {sc_c, sc_q} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            OP_SUB:  {sc_c, sc_q} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            OP_SBC:  {sc_c, sc_q} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
            OP_SHL1: begin sc_q = {a[WIDTH-2:0], cin};      sc_c = a[WIDTH-1]; end
            OP_SHR1: begin sc_q = {cin, a[WIDTH-1:1]};      sc_c = a[0];       end
            OP_ASR1: begin sc_q = {a[WIDTH-1], a[WIDTH-1:1]}; sc_c = a[0];     end
            OP_ROR1: begin sc_q = {a[0], a[WIDTH-1:1]};     sc_c = a[0];       end
            // zero-length N-bit shift passes a through with no carry
            default: sc_q = a;
        endcase
    end

    always_comb begin
        step_q = q_r;
        step_c = cout_r;
        case (op_r)
            OP_SHLN: begin step_q = {q_r[WIDTH-2:0], 1'b0};       step_c = q_r[WIDTH-1]; end
            OP_SHRN: begin step_q = {1'b0, q_r[WIDTH-1:1]};       step_c = q_r[0];       end
            OP_ASRN: begin step_q = {q_r[WIDTH-1], q_r[WIDTH-1:1]}; step_c = q_r[0];     end
            default: ;
        endcase
    end

    // {q_hi_r, q_r} is the 2W accumulator; q_r starts as the multiplier and drains LSB-first
    assign psum = {1'b0, q_hi_r} + ({1'b0, mcand} & {(WIDTH+1){q_r[0]}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            q_hi_r <= '0;
            cout_r <= 1'b0;
            op_r   <= '0;
            mcand  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        mcand  <= a;
                        q_hi_r <= '0;
                        if (op == OP_MUL) begin
                            q_r    <= b;
                            cout_r <= 1'b0;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= BUSY;
                        end else if (op >= OP_SHLN && shamt != '0) begin
                            q_r    <= a;
                            cout_r <= 1'b0;
                            cnt    <= CNT_W'(shamt);
                            state  <= BUSY;
                        end else begin
                            q_r    <= sc_q;
                            cout_r <= sc_c;
                            state  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (op_r == OP_MUL) begin
                        q_hi_r <= psum[WIDTH:1];
                        q_r    <= {psum[0], q_r[WIDTH-1:1]};
                        if (cnt == CNT_W'(1))
                            cout_r <= |psum[WIDTH:1];
                    end else begin
                        q_r    <= step_q;
                        cout_r <= step_c;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: an 8-bit and a 16-bit instance, directed vectors,
// and a per-cycle compare against an arithmetic reference model.
module tb_alu_seq;

    typedef struct {
        longint unsigned q;
        longint unsigned qh;
        bit              c;
        int              lat;
    } exp_t;

    logic        clk, rst;
    logic [1:0]  iv, ir, ov, ordy, ci, co, zr;
    logic [1:0][15:0] av, bv;
    logic [1:0][3:0]  opv;
    logic [7:0]  q8, qh8;
    logic [15:0] q16, qh16;

    int ncmp, nfail;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .op(opv[0]), .cin(ci[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .q(q8), .q_hi(qh8),
        .cout(co[0]), .zero(zr[0])
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .op(opv[1]), .cin(ci[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .q(q16), .q_hi(qh16),
        .cout(co[1]), .zero(zr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned get_q(int d);
        return (d == 0) ? {56'h0, q8} : {48'h0, q16};
    endfunction

    function automatic longint unsigned get_qh(int d);
        return (d == 0) ? {56'h0, qh8} : {48'h0, qh16};
    endfunction

    function automatic int wid(int d);
        return (d == 0) ? 8 : 16;
    endfunction

    // Reference: results from plain integer arithmetic on w-bit values
    function automatic exp_t model(int w, logic [3:0] o, longint unsigned a, longint unsigned b, bit c);
        exp_t r;
        longint unsigned m   = (64'd1 << w) - 1;
        longint unsigned msb = 64'd1 << (w - 1);
        longint unsigned s;
        longint signed   sa;
        int n = int'(b % longint'(w));
        r.q = 0; r.qh = 0; r.c = 0; r.lat = 1;
        s = 0;
        case (o)
            4'h0: r.q = a & b;
            4'h1: r.q = a | b;
            4'h2: r.q = a ^ b;
            4'h3: r.q = ~a & m;
            4'h4, 4'h5, 4'h6, 4'h7: begin
                if (o == 4'h4) s = a + b;
                if (o == 4'h5) s = a + b + c;
                if (o == 4'h6) s = a + (~b & m) + 1;
                if (o == 4'h7) s = a + (~b & m) + c;
                r.q = s & m;
                r.c = (s >> w) != 0;
            end
            4'h8: begin r.q = ((a << 1) | c) & m;         r.c = ((a >> (w-1)) & 1) != 0; end
            4'h9: begin r.q = (64'(c) << (w-1)) | (a >> 1); r.c = (a & 1) != 0; end
            4'hA: begin r.q = (a & msb) | (a >> 1);       r.c = (a & 1) != 0; end
            4'hB: begin r.q = ((a & 1) << (w-1)) | (a >> 1); r.c = (a & 1) != 0; end
            4'hC: begin
                r.q = (a << n) & m;
                r.c = (n != 0) && (((a >> (w-n)) & 1) != 0);
                r.lat = n + 1;
            end
            4'hD: begin
                r.q = a >> n;
                r.c = (n != 0) && (((a >> (n-1)) & 1) != 0);
                r.lat = n + 1;
            end
            4'hE: begin
                sa = ((a & msb) != 0) ? $signed(a | ~m) : $signed(a);
                r.q = longint'(sa >>> n) & m;
                r.c = (n != 0) && (((sa >>> (n-1)) & 1) != 0);
                r.lat = n + 1;
            end
            default: begin
                s = a * b;
                r.q = s & m;
                r.qh = s >> w;
                r.c = r.qh != 0;
                r.lat = w + 1;
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One directed transaction on instance d with hand-computed expectations
    task automatic run(input string nm, input int d, input logic [3:0] o,
                       input longint unsigned ai, input longint unsigned bi, input bit c,
                       input int hold, input longint unsigned eq, input longint unsigned eqh,
                       input bit ec, input int lat);
        exp_t m;
        int k;
        m = model(wid(d), o, ai, bi, c);
        chk({nm, "_model_q"}, m.q, eq);
        chk({nm, "_model_qhi"}, m.qh, eqh);
        chk({nm, "_model_cout"}, 64'(m.c), 64'(ec));
        chk({nm, "_model_lat"}, 64'(m.lat), 64'(lat));
        @(posedge clk); #1;
        av[d] = 16'(ai); bv[d] = 16'(bi); opv[d] = o; ci[d] = c; iv[d] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!ir[d] && k < 50);
        chk({nm, "_accept"}, 64'(ir[d]), 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        av[d] = 16'($urandom); bv[d] = 16'($urandom); opv[d] = 4'($urandom); ci[d] = ~c;
        k = 0;
        while (1) begin
            @(negedge clk); k++;
            if (ov[d] || k > 40) break;
        end
        chk({nm, "_latency"}, 64'(k), 64'(lat));
        chk({nm, "_q"}, get_q(d), eq);
        chk({nm, "_qhi"}, get_qh(d), eqh);
        chk({nm, "_cout"}, 64'(co[d]), 64'(ec));
        chk({nm, "_zero"}, 64'(zr[d]), 64'(eq == 0));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            chk({nm, "_hold_q"}, get_q(d), eq);
            chk({nm, "_hold_valid"}, 64'(ov[d]), 64'd1);
            chk({nm, "_hold_in_ready"}, 64'(ir[d]), 64'd0);
        end
        @(posedge clk); #1 ordy[d] = 1'b1;
        @(posedge clk); #1 ordy[d] = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_after"}, 64'(ir[d]), 64'd1);
    endtask

    bit   pend [2];
    int   el   [2];
    exp_t mexp [2];
    bit   rchk;

    initial begin
        ncmp = 0; nfail = 0;
        rst = 1'b1; iv = '0; ordy = '0; ci = '0; av = '0; bv = '0; opv = '0;
        pend[0] = 0; pend[1] = 0; el[0] = 0; el[1] = 0; rchk = 0;
        fork
            // per-cycle compare against the model
            forever begin
                @(negedge clk);
                if (rst) begin
                    pend[0] = 0; pend[1] = 0;
                    rchk = 1;
                end else begin
                    for (int d = 0; d < 2; d++) begin
                        bit exp_ov;
                        if (rchk) begin
                            chk($sformatf("dut%0d_rst_q", d), get_q(d), 0);
                            chk($sformatf("dut%0d_rst_qhi", d), get_qh(d), 0);
                            chk($sformatf("dut%0d_rst_cout", d), 64'(co[d]), 0);
                            chk($sformatf("dut%0d_rst_zero", d), 64'(zr[d]), 1);
                        end
                        if (pend[d]) el[d]++;
                        exp_ov = pend[d] && (el[d] >= mexp[d].lat);
                        chk($sformatf("dut%0d_in_ready", d), 64'(ir[d]), 64'(!pend[d]));
                        chk($sformatf("dut%0d_out_valid", d), 64'(ov[d]), 64'(exp_ov));
                        if (exp_ov) begin
                            chk($sformatf("dut%0d_cyc_q", d), get_q(d), mexp[d].q);
                            chk($sformatf("dut%0d_cyc_qhi", d), get_qh(d), mexp[d].qh);
                            chk($sformatf("dut%0d_cyc_cout", d), 64'(co[d]), 64'(mexp[d].c));
                            chk($sformatf("dut%0d_cyc_zero", d), 64'(zr[d]), 64'(mexp[d].q == 0));
                        end
                        if (pend[d] && ov[d] && ordy[d]) begin
                            pend[d] = 0;
                        end else if (!pend[d] && iv[d] && ir[d]) begin
                            pend[d] = 1;
                            el[d] = 0;
                            mexp[d] = model(wid(d), opv[d],
                                            longint'(av[d]) & ((64'd1 << wid(d)) - 1),
                                            longint'(bv[d]) & ((64'd1 << wid(d)) - 1), ci[d]);
                        end
                    end
                    rchk = 0;
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("init_in_ready", 64'(ir[0]), 1);

                run("add_wrap",  0, 4'h4, 'hFF, 'h01, 0, 0, 'h00, 0, 1, 1);
                run("sub_borrow",0, 4'h6, 'h10, 'h20, 0, 0, 'hF0, 0, 0, 1);
                run("adc",       0, 4'h5, 'h7F, 'h80, 1, 0, 'h00, 0, 1, 1);
                run("sbc",       0, 4'h7, 'h05, 'h05, 0, 0, 'hFF, 0, 0, 1);
                run("and",       0, 4'h0, 'hF0, 'h3C, 0, 0, 'h30, 0, 0, 1);
                run("or",        0, 4'h1, 'hF0, 'h3C, 1, 0, 'hFC, 0, 0, 1);
                run("not",       0, 4'h3, 'h0F, 'h00, 0, 0, 'hF0, 0, 0, 1);
                run("shl1",      0, 4'h8, 'h80, 'h00, 1, 0, 'h01, 0, 1, 1);
                run("shr1",      0, 4'h9, 'h01, 'h00, 1, 0, 'h80, 0, 1, 1);
                run("asr1",      0, 4'hA, 'h81, 'h00, 0, 0, 'hC0, 0, 1, 1);
                run("ror1",      0, 4'hB, 'h02, 'h00, 0, 0, 'h01, 0, 0, 1);
                run("asrn3",     0, 4'hE, 'h80, 'h03, 0, 0, 'hF0, 0, 0, 4);
                run("shln1",     0, 4'hC, 'h81, 'h01, 0, 0, 'h02, 0, 1, 2);
                run("shrn0",     0, 4'hD, 'h5A, 'h08, 1, 0, 'h5A, 0, 0, 1);
                run("shrn7",     0, 4'hD, 'h80, 'h07, 0, 0, 'h01, 0, 0, 8);
                run("mul_max",   0, 4'hF, 'hFF, 'hFF, 0, 0, 'h01, 'hFE, 1, 9);
                run("mul_small", 0, 4'hF, 'h03, 'h05, 0, 0, 'h0F, 'h00, 0, 9);
                run("xor_bp",    0, 4'h2, 'hA5, 'hFF, 0, 5, 'h5A, 0, 0, 1);

                // reset three cycles into a multiply
                @(posedge clk); #1;
                av[0] = 16'h00FF; bv[0] = 16'h00FF; opv[0] = 4'hF; iv[0] = 1'b1;
                @(negedge clk);
                chk("rstmul_accept", 64'(ir[0]), 1);
                @(posedge clk); #1 iv[0] = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("rstmul_out_valid", 64'(ov[0]), 0);
                chk("rstmul_q", get_q(0), 0);
                chk("rstmul_qhi", get_qh(0), 0);
                chk("rstmul_cout", 64'(co[0]), 0);
                chk("rstmul_zero", 64'(zr[0]), 1);
                chk("rstmul_in_ready", 64'(ir[0]), 1);
                run("add_after_rst", 0, 4'h4, 'h02, 'h03, 0, 0, 'h05, 0, 0, 1);

                run("w16_ror1",  1, 4'hB, 'h0001, 'h0000, 0, 0, 'h8000, 0, 1, 1);
                run("w16_mul",   1, 4'hF, 'hFFFF, 'h0002, 0, 0, 'hFFFE, 'h0001, 1, 17);
                run("w16_shln15",1, 4'hC, 'h0001, 'h000F, 0, 0, 'h8000, 0, 0, 16);
                run("w16_asrn",  1, 4'hE, 'h8001, 'h0004, 0, 2, 'hF800, 0, 0, 5);
                repeat (3) @(posedge clk);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Width-parametrised, handshaked successor to the 8-bit combinational ALU.
- Keeps the logic, add/sub-with-carry and single-bit shift/rotate classes, each now with a registered result.
- Adds iterative multi-bit shifts (one bit per cycle) and an iterative unsigned shift-add multiply with a double-width result.
- Sits between the register-file read stage and writeback. Upstream stalls on in_ready; downstream drains through out_valid/out_ready.

Parameters:
- WIDTH, 8, operand/result width. Must be a power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), derived localparam. Width of the shift-amount field taken from b.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount for N-bit shifts
- op  in  4  operation select
- cin  in  1  carry/shift-in bit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- q  out  WIDTH  result (low half for MUL)
- q_hi  out  WIDTH  high half of MUL product; 0 for all other ops
- cout  out  1  carry / last bit shifted out / MUL overflow
- zero  out  1  q == 0

Behaviour:
- States: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept happens when in_valid && in_ready. a, b, op and cin are captured at accept; later input changes are ignored.
- Single-cycle ops (0x0-0xB): result is computed at accept and registered. State goes IDLE->DONE, so out_valid rises the cycle after accept (latency 1).
- Op encoding (W=WIDTH):
  - 0x0 AND, 0x1 OR, 0x2 XOR, 0x3 NOT a. cout=0 for all four.
  - 0x4 ADD: {cout,q}=a+b.
  - 0x5 ADC: a+b+cin.
  - 0x6 SUB: a+~b+1. 0x7 SBC: a+~b+cin. For both, cout=1 means no borrow.
  - 0x8 SHL1: q={a[W-2:0],cin}, cout=a[W-1].
  - 0x9 SHR1: q={cin,a[W-1:1]}, cout=a[0].
  - 0xA ASR1: q={a[W-1],a[W-1:1]}, cout=a[0].
  - 0xB ROR1: q={a[0],a[W-1:1]}, cout=a[0].
  - 0xC SHLN, 0xD SHRN (logical, zero fill), 0xE ASRN (sign fill): shift a by n=b[SHAMT_W-1:0].
  - 0xF MUL: unsigned a*b. q=product[W-1:0], q_hi=product[2W-1:W], cout=|q_hi.
- N-bit shifts:
  - n==0: behaves as a single-cycle op. q=a, cout=0, latency 1.
  - n>0: IDLE->BUSY with counter=n. One-bit shift per BUSY cycle; cout tracks the bit shifted out on the latest step. When the counter reaches 0 after a step, go to DONE. out_valid rises n+1 cycles after accept.
- MUL: IDLE->BUSY with counter=WIDTH. Radix-2 shift-add, one multiplier bit per cycle, using a 2W accumulator. out_valid rises WIDTH+1 cycles after accept.
- DONE:
  - q, q_hi, cout and zero are held stable while out_ready is low.
  - out_valid && out_ready moves to IDLE. in_ready goes high the following cycle; there is no same-cycle re-accept.
- q_hi=0 for every op except MUL. zero is derived from the registered q.
- Reset (rst=1 at a clock edge, any state, including mid-BUSY):
  - state=IDLE; q=0, q_hi=0, cout=0, zero=1; in-flight work is discarded.
  - The cycle after rst deasserts, in_ready=1.
  - rst takes priority over any simultaneous accept or handshake.
- in_valid is ignored outside IDLE; the upstream holds its request until in_ready.

Test Plan (WIDTH=8 unless stated):
- ADD a=0xFF b=0x01 cin=0 -> q=0x00, cout=1, zero=1, out_valid exactly 1 cycle after accept. Then SUB a=0x10 b=0x20 -> q=0xF0, cout=0.
- ASRN a=0x80 b=0x03 -> q=0xF0, cout=0, out_valid 4 cycles after accept, in_ready low throughout. Also SHLN a=0x81 b=0x01 -> q=0x02, cout=1. Also SHRN with b=0 -> q=a, cout=0, latency 1.
- MUL a=0xFF b=0xFF -> q=0x01, q_hi=0xFE, cout=1, latency 9. MUL a=0x03 b=0x05 -> q=0x0F, q_hi=0x00, cout=0.
- Backpressure: complete an XOR a=0xA5 b=0xFF, hold out_ready=0 for 5 cycles -> q=0x5A held stable, out_valid=1, in_ready=0. Release -> in_ready=1 the next cycle.
- Reset mid-op: assert rst 3 cycles into a MUL -> the next cycle shows out_valid=0, q=0, q_hi=0, cout=0, zero=1. in_ready=1 after rst deasserts; a following ADD 2+3 returns 0x05.
- WIDTH=16: ROR1 a=0x0001 -> q=0x8000, cout=1. MUL 0xFFFF*0x0002 -> q=0xFFFE, q_hi=0x0001, latency 17.
